// File: rtl/spi_pkg.sv
// Shared types and constants for the two-requester SPI master arbiter.
package spi_pkg;

    localparam int DW_DEF = 14;
    localparam int RW_DEF = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        ISSUE     = ST_ISSUE,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE,
        RESP      = ST_RESP
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: a lone request wins outright,
// contention goes to the requester that did not win last time.
module rr_arb2
    import spi_pkg::*;
(
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic [1:0] grant_oh_o
);

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        grant_o    = REQ0;
        grant_oh_o = 2'b00;
        if (req_valid_i == 2'b11) begin
            grant_o = ~last_grant_i;
        end else if (req_valid_i[REQ1]) begin
            grant_o = REQ1;
        end
        if (|req_valid_i) begin
            grant_oh_o = (grant_o == REQ1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one spi_master between two requesters (requester i drives CS i),
// with round-robin grant and busy/done timeouts on the master's rx_ready.
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int BUSY_TO = 4,
    parameter int DONE_TO = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    output logic [1:0]    req_ready,
    output logic [1:0]    rsp_valid,
    output logic [RW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          spi_tx_valid,
    output logic [DW-1:0] spi_data_in,
    output logic          spi_cs_sel,
    input  logic          spi_rx_ready,
    input  logic [RW-1:0] spi_data_out,
    output logic          busy
);

    localparam int TW = $clog2(max2(BUSY_TO, DONE_TO)) + 1;
    localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TO - 1);
    localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TO - 1);
    localparam logic [TW-1:0] TIMER_MAX = '1;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] data_in_q, data_in_d;
    logic [RW-1:0] rsp_data_q, rsp_data_d;
    logic          err_q, err_d;
    logic          first_done_q, first_done_d;
    logic          rx_q;

    logic          arb_grant;
    logic [1:0]    arb_oh;
    logic          can_accept;
    logic          accept;
    logic [TW-1:0] timer_inc;

    rr_arb2 u_arb (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_oh_o   (arb_oh)
    );

    // A fresh master's rx_ready is not trustworthy, so the very first issue
    // after reset is qualified by first_done instead. Reset also forces
    // req_ready low so every output is zero while rst is held.
    assign can_accept = rst && (state_q == IDLE) && (spi_rx_ready || !first_done_q);
    assign req_ready  = can_accept ? arb_oh : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign timer_inc  = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        timer_d      = timer_q;
        data_in_d    = data_in_q;
        rsp_data_d   = rsp_data_q;
        err_d        = err_q;
        first_done_d = first_done_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_in_d    = (arb_grant == REQ1) ? req_data1 : req_data0;
                    owner_d      = arb_grant;
                    last_grant_d = arb_grant;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!rx_q) begin
                    timer_d = '0;
                    state_d = WAIT_DONE;
                end else if (timer_q == BUSY_LAST) begin
                    err_d      = 1'b1;
                    rsp_data_d = '0;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_inc;
                end
            end
            WAIT_DONE: begin
                if (rx_q) begin
                    rsp_data_d = spi_data_out;
                    err_d      = 1'b0;
                    state_d    = RESP;
                end else if (timer_q == DONE_LAST) begin
                    err_d      = 1'b1;
                    rsp_data_d = '0;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_inc;
                end
            end
            RESP: begin
                first_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ1;
            owner_q      <= REQ0;
            timer_q      <= '0;
            data_in_q    <= '0;
            rsp_data_q   <= '0;
            err_q        <= 1'b0;
            first_done_q <= 1'b0;
            rx_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            timer_q      <= timer_d;
            data_in_q    <= data_in_d;
            rsp_data_q   <= rsp_data_d;
            err_q        <= err_d;
            first_done_q <= first_done_d;
            rx_q         <= spi_rx_ready;
        end
    end

    // rx_ready is registered once, so its rise reaches rsp_valid two cycles later.
    assign spi_tx_valid = (state_q == ISSUE);
    assign spi_data_in  = data_in_q;
    assign spi_cs_sel   = owner_q;
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = (state_q != RESP) ? 2'b00 :
                          (owner_q == REQ1) ? 2'b10 : 2'b01;
    assign rsp_err      = (state_q == RESP) && err_q;
    assign rsp_data     = rsp_data_q;

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one spi_master between two requesters, one per slave chip-select.
- Requester 0 targets CS0 and requester 1 targets CS1.
- Accepts 14-bit transmit words from each requester and arbitrates round-robin.
- Drives the master's tx_valid/Data_in/CS_Sel, tracks the master's rx_ready level, and returns the 8-bit receive byte (or a timeout error) to the owning requester.

Parameters:
- DW, 14, transmit word width (matches master Data_in).
- RW, 8, receive byte width (matches master Data_out).
- BUSY_TO, 4, cycles allowed for rx_ready to fall after issue.
- DONE_TO, 64, cycles allowed for rx_ready to rise after it has fallen.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_data0  in  DW  requester 0 transmit word.
- req_data1  in  DW  requester 1 transmit word.
- req_ready  out  2  per-requester accept; transfer when req_valid[i]&req_ready[i].
- rsp_valid  out  2  one-cycle pulse to the owning requester.
- rsp_data  out  RW  receive byte, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- spi_tx_valid  out  1  to master tx_valid.
- spi_data_in  out  DW  to master Data_in.
- spi_cs_sel  out  1  to master CS_Sel; equals owner index.
- spi_rx_ready  in  1  from master rx_ready (level).
- spi_data_out  in  RW  from master Data_out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, last_grant=1, owner=0, timer=0. All outputs 0; spi_data_in=0.
- A mid-transaction reset abandons the transaction and produces no rsp_valid. The master must be reset by the same rst.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE, grant:
  - Only one valid: grant it.
  - Both valid: grant index != last_grant.
  - req_ready is combinational: one-hot of the grant, asserted only in IDLE and only when spi_rx_ready==1 or after reset. A fresh master has rx_ready X/0, so the first-issue qualifier is a registered flag "first_done", cleared by reset.
- On accept: latch word into spi_data_in, owner<=grant, last_grant<=grant, spi_cs_sel<=grant. Next state ISSUE.
- ISSUE: spi_tx_valid=1 for exactly one cycle; timer<=0; next WAIT_BUSY.
- WAIT_BUSY: wait for spi_rx_ready==0.
  - Seen: timer<=0, go to WAIT_DONE.
  - timer==BUSY_TO-1: set err, go to RESP.
- WAIT_DONE: wait for spi_rx_ready==1.
  - Seen: capture spi_data_out into rsp_data, err=0, go to RESP.
  - timer==DONE_TO-1: err=1, rsp_data=0, go to RESP.
- RESP: rsp_valid[owner]=1 for one cycle, rsp_err=err; set first_done; return to IDLE.
- Issue-to-accept latency:
  - Accept to spi_tx_valid = 1 cycle.
  - Master rx_ready rise to rsp_valid = 2 cycles.
  - A nominal master transfer of 18 bit-cycles gives about 22 cycles per transaction.
- Back-to-back: a new accept is possible in the IDLE cycle directly after RESP. No bubble beyond that is required.
- Requests are not queued: req_valid held while not ready simply waits.
- Dropping req_valid before accept is legal and causes no side effects.
- spi_data_in and spi_cs_sel hold stable from accept until the next accept, so CS routing is stable for the whole transfer.
- Timer width is clog2(max(BUSY_TO,DONE_TO))+1. Timers saturate and never wrap.

Decomposition:
- Shared package spi_pkg:
  - State encoding localparams (IDLE..RESP).
  - DW/RW defaults.
  - Requester index constants REQ0=0, REQ1=1.
- One natural sub-module: rr_arb2 (combinational 2-way round-robin grant from req_valid and last_grant, plus one-hot output).
- Everything else stays in the top block.

Test Plan:
- Single request: req_valid=2'b01, req_data0=14'h2A5B, slave returns 8'hC3.
  - Required: one spi_tx_valid pulse, spi_cs_sel=0, spi_data_in=14'h2A5B.
  - Required: rsp_valid=2'b01, rsp_data=8'hC3, rsp_err=0; busy low afterwards.
- Contention: both req_valid high continuously, data 14'h0001/14'h0002.
  - Required: grants alternate 0,1,0,1 over 4 transactions, with spi_cs_sel matching.
  - Required: rsp_valid goes to the correct requester each time.
- Stalled master: tie spi_rx_ready=1 permanently after the first transaction.
  - Required: the next request yields rsp_err=1 exactly BUSY_TO cycles after ISSUE, then returns to IDLE.
- Hung transfer: spi_rx_ready forced 0 after issue.
  - Required: rsp_err=1, rsp_data=0 after DONE_TO cycles in WAIT_DONE, delivered to the correct owner.
- Reset mid-transfer: assert rst low during WAIT_DONE.
  - Required: all outputs 0 immediately (asynchronously), no rsp_valid.
  - Required: after release, requester 0 is granted first.
- Withdrawn request: req_valid[1] pulsed for one cycle while busy.
  - Required: no grant, and no spi_tx_valid for requester 1.
